ecc_decoder: RTL
================

// Module: ecc_decoder
// PURPOSE
// - Pipelined SECDED Hamming decoder paired with ecc_encoder; sits on the memory read-return path.
// - Takes a stored codeword, corrects any single-bit error, flags double-bit errors, and returns the data bits.
// - Valid/ready handshake on both sides; saturating error counters feed the scrub/health logic.
// PARAMETERS
// - data_bit_width      64  data bits per codeword
// - redundant_bit_width 8   check bits (parity[0] overall + Hamming bits); N = data+redundant
// - cnt_width           16  width of each error counter
// PORTS
// - clk             in   1      clock; all logic rising-edge
// - rst             in   1      reset, synchronous, active-high
// - dec_in_valid    in   1      input codeword valid
// - dec_in_ready    out  1      decoder can accept a codeword
// - dec_data_in     in   N      codeword; bit 0 = overall parity; bit 2^m = Hamming parity m+1; data bits ascending in remaining positions
// - dec_out_valid   out  1      output word valid
// - dec_out_ready   in   1      downstream accepts
// - dec_data_out    out  data   corrected data
// - dec_single_err  out  1      single error corrected (qualified by dec_out_valid)
// - dec_double_err  out  1      uncorrectable error (qualified by dec_out_valid)
// - dec_err_pos     out  R-1    syndrome / codeword position of the corrected bit; 0 when clean
// - cnt_clr         in   1      synchronous clear of both counters
// - corr_cnt        out  cnt_w  saturating count of single errors
// - uncorr_cnt      out  cnt_w  saturating count of double/uncorrectable errors
// BEHAVIOUR
// - Reset: dec_out_valid=0, dec_in_ready=1 the cycle after reset, data/flags/pos=0, counters=0; in-flight words dropped.
// - Stage 1 (on accept, dec_in_valid&&dec_in_ready): register codeword, syndrome S (S[m] = XOR of bits whose index has bit m set), and P = XOR of all N bits.
// - Stage 2: classify, correct, extract data, and register outputs. Latency 2 cycles from accept to dec_out_valid when there is no stall.
// - Classification:
//   - S==0,P==0: clean.
//   - P==1,S<N: single; flip bit S (S==0 means the parity bit itself, data unchanged); err_pos=S.
//   - P==1,S>=N: uncorrectable; double=1.
//   - S!=0,P==0: double=1.
// - On double=1: dec_data_out = uncorrected data bits; single=0.
// - Handshake: s2 loads when !s2_valid || dec_out_ready; s1 advances when !s1_valid || s2 loads.
// - dec_in_ready = !s1_valid || s2 loads. This is a combinational path from dec_out_ready; full throughput of 1 word/cycle.
// - Outputs hold stable while dec_out_valid && !dec_out_ready.
// - Counters increment on the output handshake (dec_out_valid&&dec_out_ready) per the flags. They saturate at all-ones, with no wrap.
// - cnt_clr has priority over a same-cycle increment; the counter reads 0 next cycle.
// CONFIGURATION
// - Macro ECC_DEC_ERR_LOG_EN adds ports err_log_valid(1), err_log_pos(R-1), err_log_double(1).
//   - The first error at the output handshake after reset or cnt_clr is latched; later errors are ignored until cnt_clr.
//   - On a same-cycle cnt_clr and error, the log is cleared and the new error is not captured.
// - Without the macro: ports and logic are absent; all other behaviour is identical.
// TESTING (64/8 config, data D=0x0123_4567_89AB_CDEF encoded by ecc_encoder)
// - Clean D, out_ready=1 -> 2 cycles later out=D, single=0, double=0, pos=0; counters unchanged.
// - D with codeword bit 3 flipped -> out=D, single=1, pos=3, corr_cnt=1.
// - D with bits 3 and 5 flipped -> double=1, single=0, uncorr_cnt=1; with the macro, log holds pos=6 and double=1.
// - D with bit 0 flipped -> out=D, single=1, pos=0.
// - Backpressure: out_ready=0, stream 3 words -> exactly 2 accepted, then in_ready=0. Release -> words emerge in order, none lost or duplicated.
// - cnt_width=2: 5 single errors -> corr_cnt=3. cnt_clr with a simultaneous error -> 0.
//   rst asserted with both stages full -> dec_out_valid=0 the next cycle.

Source files
------------

// File: rtl/ecc_decoder.sv
// Two-stage SECDED Hamming decoder for the memory read-return path, with saturating error counters.
// Optional first-error log ports are enabled by defining ECC_DEC_ERR_LOG_EN.
module ecc_decoder #(
  parameter int data_bit_width      = 64,
  parameter int redundant_bit_width = 8,
  parameter int cnt_width           = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          dec_in_valid,
  output logic                                          dec_in_ready,
  input  logic [data_bit_width+redundant_bit_width-1:0] dec_data_in,
  output logic                                          dec_out_valid,
  input  logic                                          dec_out_ready,
  output logic [data_bit_width-1:0]                     dec_data_out,
  output logic                                          dec_single_err,
  output logic                                          dec_double_err,
  output logic [redundant_bit_width-2:0]                dec_err_pos,
  input  logic                                          cnt_clr,
  output logic [cnt_width-1:0]                          corr_cnt,
`ifdef ECC_DEC_ERR_LOG_EN
  output logic                                          err_log_valid,
  output logic [redundant_bit_width-2:0]                err_log_pos,
  output logic                                          err_log_double,
`endif
  output logic [cnt_width-1:0]                          uncorr_cnt
);

  localparam int N  = data_bit_width + redundant_bit_width;
  localparam int PW = redundant_bit_width - 1;

  function automatic logic [PW-1:0] calc_syndrome(input logic [N-1:0] cw);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++)
      for (int m = 0; m < PW; m++)
        if (i[m]) s[m] = s[m] ^ cw[i];
    return s;
  endfunction

  // Data bits occupy every non-power-of-two position above 0, in ascending order.
  function automatic logic [data_bit_width-1:0] extract_data(input logic [N-1:0] cw);
    logic [data_bit_width-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int i = 1; i < N; i++)
      if ((i & (i - 1)) != 0) begin
        d[k] = cw[i];
        k++;
      end
    return d;
  endfunction

  function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic                      vld_p1_q, vld_p1_d;
  logic [N-1:0]              cw_p1_q, cw_p1_d;
  logic [PW-1:0]             syn_p1_q, syn_p1_d;
  logic                      par_p1_q, par_p1_d;
  logic                      vld_p2_q, vld_p2_d;
  logic [data_bit_width-1:0] data_p2_q, data_p2_d;
  logic                      single_p2_q, single_p2_d;
  logic                      double_p2_q, double_p2_d;
  logic [PW-1:0]             pos_p2_q, pos_p2_d;
  logic [cnt_width-1:0]      corr_cnt_q, corr_cnt_d;
  logic [cnt_width-1:0]      uncorr_cnt_q, uncorr_cnt_d;
  logic                      s2_load, accept, out_fire;
  logic                      cls_single, cls_double;
  logic [N-1:0]              cw_fixed;

  always_comb begin
    s2_load      = !vld_p2_q || dec_out_ready;
    dec_in_ready = !vld_p1_q || s2_load;
    accept       = dec_in_valid && dec_in_ready;
    out_fire     = vld_p2_q && dec_out_ready;

    // Stage p1: capture codeword with its syndrome and overall parity
    vld_p1_d = dec_in_ready ? dec_in_valid : vld_p1_q;
    cw_p1_d  = cw_p1_q;
    syn_p1_d = syn_p1_q;
    par_p1_d = par_p1_q;
    if (accept) begin
      cw_p1_d  = dec_data_in;
      syn_p1_d = calc_syndrome(dec_data_in);
      par_p1_d = ^dec_data_in;
    end

    // Stage p2: classify, correct and extract
    cls_single = 1'b0;
    cls_double = 1'b0;
    cw_fixed   = cw_p1_q;
    if (par_p1_q) begin
      if (int'(syn_p1_q) < N) begin
        cls_single = 1'b1;
        cw_fixed   = cw_p1_q ^ ({{(N-1){1'b0}}, 1'b1} << syn_p1_q);
      end else begin
        cls_double = 1'b1;
      end
    end else if (syn_p1_q != '0) begin
      cls_double = 1'b1;
    end

    vld_p2_d    = s2_load ? vld_p1_q : vld_p2_q;
    data_p2_d   = data_p2_q;
    single_p2_d = single_p2_q;
    double_p2_d = double_p2_q;
    pos_p2_d    = pos_p2_q;
    if (s2_load && vld_p1_q) begin
      data_p2_d   = extract_data(cw_fixed);
      single_p2_d = cls_single;
      double_p2_d = cls_double;
      pos_p2_d    = syn_p1_q;
    end

    // Clear wins over a same-cycle increment
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_fire) begin
      if (single_p2_q) corr_cnt_d   = sat_inc(corr_cnt_q);
      if (double_p2_q) uncorr_cnt_d = sat_inc(uncorr_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    cw_p1_q  <= cw_p1_d;
    syn_p1_q <= syn_p1_d;
    par_p1_q <= par_p1_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      data_p2_q    <= '0;
      single_p2_q  <= 1'b0;
      double_p2_q  <= 1'b0;
      pos_p2_q     <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      vld_p1_q     <= vld_p1_d;
      vld_p2_q     <= vld_p2_d;
      data_p2_q    <= data_p2_d;
      single_p2_q  <= single_p2_d;
      double_p2_q  <= double_p2_d;
      pos_p2_q     <= pos_p2_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign dec_out_valid  = vld_p2_q;
  assign dec_data_out   = data_p2_q;
  assign dec_single_err = single_p2_q;
  assign dec_double_err = double_p2_q;
  assign dec_err_pos    = pos_p2_q;
  assign corr_cnt       = corr_cnt_q;
  assign uncorr_cnt     = uncorr_cnt_q;

`ifdef ECC_DEC_ERR_LOG_EN
  logic          log_valid_q, log_valid_d;
  logic [PW-1:0] log_pos_q, log_pos_d;
  logic          log_double_q, log_double_d;

  // Only the first error after reset/clear is kept; a clear suppresses a same-cycle capture
  always_comb begin
    log_valid_d  = log_valid_q;
    log_pos_d    = log_pos_q;
    log_double_d = log_double_q;
    if (cnt_clr) begin
      log_valid_d  = 1'b0;
      log_pos_d    = '0;
      log_double_d = 1'b0;
    end else if (out_fire && (single_p2_q || double_p2_q) && !log_valid_q) begin
      log_valid_d  = 1'b1;
      log_pos_d    = pos_p2_q;
      log_double_d = double_p2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      log_valid_q  <= 1'b0;
      log_pos_q    <= '0;
      log_double_q <= 1'b0;
    end else begin
      log_valid_q  <= log_valid_d;
      log_pos_q    <= log_pos_d;
      log_double_q <= log_double_d;
    end
  end

  assign err_log_valid  = log_valid_q;
  assign err_log_pos    = log_pos_q;
  assign err_log_double = log_double_q;
`endif

endmodule
